// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment codes,
// blanking constants and the scan state encoding.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ON,
        ST_GAP
    } scan_state_e;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         SEG_DP_BIT = 7;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for hex 0..F, dp off
    localparam logic [7:0] SEG_CODES [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational hex nibble + decimal point to active-low segment drive.
module seg_digit_decode (
    input  logic [3:0] i_nib,
    input  logic       i_dp,
    output logic [7:0] o_seg_n
);
    import seg_pkg::*;

    always_comb begin
        o_seg_n = SEG_CODES[i_nib];
        if (i_dp) begin
            o_seg_n[SEG_DP_BIT] = 1'b0;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous commit of
// host writes. Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_MAX    = 49999,
    parameter int GAP_CYC    = 2,
    parameter int DIV_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic                    pending,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [7:0]              seg_n
);
    import seg_pkg::*;

    localparam int               DIG_W    = $clog2(NUM_DIGITS);
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] ON_LAST  = DIV_W'(DIV_MAX);
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(GAP_CYC - 1);

    scan_state_e              r_state, w_state_nxt;
    logic [DIG_W-1:0]         r_digit, w_digit_nxt;
    logic [DIV_W-1:0]         r_cnt, w_cnt_nxt;
    logic                     w_commit;

    logic [4*NUM_DIGITS-1:0]  r_act_val, r_sh_val;
    logic [NUM_DIGITS-1:0]    r_act_dp, r_sh_dp;
    logic                     r_pending;

    logic [NUM_DIGITS-1:0]    r_an_n, w_an_n;
    logic [7:0]               r_seg_n, w_seg_n;
    logic                     r_frame_start;
    logic [3:0]               w_nib;
    logic                     w_dp;
    logic                     w_blank;

    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        if (!en) begin
            w_state_nxt = ST_OFF;
            w_digit_nxt = '0;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_ON;
                    w_digit_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_commit    = r_pending;
                end
                ST_ON: begin
                    if (r_cnt == ON_LAST) begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_state_nxt = ST_ON;
                        w_cnt_nxt   = '0;
                        if (r_digit == LAST_DIG) begin
                            w_digit_nxt = '0;
                            w_commit    = r_pending;
                        end else begin
                            w_digit_nxt = r_digit + DIG_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + DIV_W'(1);
                    end
                end
                default: w_state_nxt = ST_OFF;
            endcase
        end
    end

    // A load coinciding with a commit lands in the shadow after the commit
    // has taken the old contents, so pending stays set for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_OFF;
            r_digit   <= '0;
            r_cnt     <= '0;
            r_act_val <= '0;
            r_act_dp  <= '0;
            r_sh_val  <= '0;
            r_sh_dp   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_digit <= w_digit_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_commit) begin
                r_act_val <= r_sh_val;
                r_act_dp  <= r_sh_dp;
            end
            if (load) begin
                r_sh_val <= load_val;
                r_sh_dp  <= load_dp;
            end
            r_pending <= load | (r_pending & ~w_commit);
        end
    end

    assign w_nib = r_act_val[{r_digit, 2'b00} +: 4];
    assign w_dp  = r_act_dp[r_digit];

    seg_digit_decode u_decode (
        .i_nib   (w_nib),
        .i_dp    (w_dp),
        .o_seg_n (w_seg_n)
    );

    always_comb begin
        w_an_n          = '1;
        w_an_n[r_digit] = 1'b0;
    end

`ifdef SEG_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] w_lead_zero;
    logic                  w_zero_run;

    // Walk from the most significant digit down; digit 0 is never blanked
    always_comb begin
        w_lead_zero = '0;
        w_zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_zero_run     = w_zero_run & (r_act_val[4*i +: 4] == 4'h0) & ~r_act_dp[i];
            w_lead_zero[i] = w_zero_run;
        end
    end

    assign w_blank = w_lead_zero[r_digit];
`else
    assign w_blank = 1'b0;
`endif

    // Output stage lags state by one cycle; en low darkens it immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an_n        <= '1;
            r_seg_n       <= SEG_BLANK;
            r_frame_start <= 1'b0;
        end else begin
            if (en && (r_state == ST_ON) && !w_blank) begin
                r_an_n  <= w_an_n;
                r_seg_n <= w_seg_n;
            end else begin
                r_an_n  <= '1;
                r_seg_n <= SEG_BLANK;
            end
            r_frame_start <= en && (r_state == ST_ON) && (r_digit == '0) && (r_cnt == '0);
        end
    end

    assign an_n        = r_an_n;
    assign seg_n       = r_seg_n;
    assign frame_start = r_frame_start;
    assign pending     = r_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a hand-written vector table for the
// first frame plus a frame-position reference model feeding a scoreboard.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DM    = 3;
    localparam int GC    = 1;
    localparam int PER   = DM + 1 + GC;
    localparam int FRAME = ND * PER;

    typedef struct {
        string      name;
        logic [3:0] an;
        logic [7:0] seg;
        bit         fs;
        bit         pend;
    } exp_t;

    typedef struct {
        bit          en;
        bit          ld;
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  an;
        logic [7:0]  seg;
        bit          fs;
        bit          pend;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] loadVal;
    logic [3:0]  loadDp;
    logic        pending;
    logic        frameStart;
    logic [3:0]  anN;
    logic [7:0]  segN;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // reference model: scan position counted from the start of the frame
    bit          mOn;
    int          mPos;
    logic [15:0] mActVal, mShVal;
    logic [3:0]  mActDp, mShDp;
    bit          mPend;

    logic [7:0] segTab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E
    };

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .DIV_MAX    (DM),
        .GAP_CYC    (GC),
        .DIV_W      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .load_val    (loadVal),
        .load_dp     (loadDp),
        .pending     (pending),
        .frame_start (frameStart),
        .an_n        (anN),
        .seg_n       (segN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    function automatic exp_t modelOut(input bit enNow);
        exp_t e;
        int   slot;
        int   dig;
        bit   blank;
        e.name = "";
        e.an   = 4'hF;
        e.seg  = 8'hFF;
        e.fs   = 1'b0;
        e.pend = 1'b0;
        if (enNow && mOn) begin
            slot  = mPos % PER;
            dig   = mPos / PER;
            blank = 1'b0;
`ifdef SEG_SCAN_LZB_EN
            blank = (dig != 0);
            for (int j = dig; j < ND; j++) begin
                if (mActVal[4*j +: 4] != 4'h0 || mActDp[j]) blank = 1'b0;
            end
`endif
            if (slot <= DM && !blank) begin
                e.an[dig] = 1'b0;
                e.seg     = segTab[mActVal[4*dig +: 4]];
                if (mActDp[dig]) e.seg[7] = 1'b0;
            end
            e.fs = (mPos == 0);
        end
        return e;
    endfunction

    task automatic updateModel(input bit e, input bit ld, input logic [15:0] v, input logic [3:0] d);
        bit doCommit;
        doCommit = 1'b0;
        if (!e) begin
            mOn  = 1'b0;
            mPos = 0;
        end else if (!mOn) begin
            mOn      = 1'b1;
            mPos     = 0;
            doCommit = 1'b1;
        end else begin
            mPos     = (mPos + 1) % FRAME;
            doCommit = (mPos == 0);
        end
        if (doCommit && mPend) begin
            mActVal = mShVal;
            mActDp  = mShDp;
            mPend   = 1'b0;
        end
        if (ld) begin
            mShVal = v;
            mShDp  = d;
            mPend  = 1'b1;
        end
    endtask

    task automatic cmp(input string nm, input string field, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s %s got=%0h want=%0h", nm, field, got, want);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard empty got=0 want=1");
        end else begin
            e = sb.pop_front();
            cmp(e.name, "an_n", 32'(anN), 32'(e.an));
            cmp(e.name, "seg_n", 32'(segN), 32'(e.seg));
            cmp(e.name, "frame_start", 32'(frameStart), 32'(e.fs));
            cmp(e.name, "pending", 32'(pending), 32'(e.pend));
            cmp(e.name, "anodes_low_le1", 32'($countones(~anN) <= 1), 32'd1);
        end
    endtask

    // drive one cycle of inputs, queue the expectation, then sample after the edge
    task automatic applyStimulus(input bit e, input bit ld, input logic [15:0] v, input logic [3:0] d,
                                 input bit useTbl, input exp_t tExp);
        exp_t m;
        en      = e;
        load    = ld;
        loadVal = v;
        loadDp  = d;
        m = modelOut(e);
        updateModel(e, ld, v, d);
        m.pend = mPend;
        m.name = tExp.name;
        if (useTbl) sb.push_back(tExp);
        else        sb.push_back(m);
        @(posedge clk);
        #1;
        checkOutput();
        load = 1'b0;
    endtask

    task automatic step(input bit e, input bit ld, input logic [15:0] v, input logic [3:0] d, input string nm);
        exp_t t;
        t.name = nm;
        t.an   = 4'hF;
        t.seg  = 8'hFF;
        t.fs   = 1'b0;
        t.pend = 1'b0;
        applyStimulus(e, ld, v, d, 1'b0, t);
    endtask

    task automatic runUntil(input int target, input string nm);
        for (int i = 0; i < 2 * FRAME && !(mOn && mPos == target); i++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, nm);
        end
        if (!(mOn && mPos == target)) begin
            total++;
            bad++;
            $display("[TB] FAIL %s position got=%0d want=%0d", nm, mPos, target);
        end
    endtask

    vec_t       tbl [24];
    logic [3:0] anExp  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] segExp [4] = '{8'h99, 8'h30, 8'hA4, 8'hF9};

    initial begin
        exp_t te;
        int   slot;
        int   dig;

        tbl[0] = '{1'b0, 1'b0, 16'h0000, 4'b0000, 4'hF, 8'hFF, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 16'h1234, 4'b0010, 4'hF, 8'hFF, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 16'h0000, 4'b0000, 4'hF, 8'hFF, 1'b0, 1'b0};
        for (int k = 0; k <= FRAME; k++) begin
            slot = k % PER;
            dig  = (k / PER) % ND;
            tbl[3+k] = '{1'b1, 1'b0, 16'h0000, 4'b0000, 4'hF, 8'hFF, (k % FRAME) == 0, 1'b0};
            if (slot <= DM) begin
                tbl[3+k].an  = anExp[dig];
                tbl[3+k].seg = segExp[dig];
            end
        end

        rst     = 1'b1;
        en      = 1'b0;
        load    = 1'b0;
        loadVal = 16'h0;
        loadDp  = 4'h0;
        mOn     = 1'b0;
        mPos    = 0;
        mActVal = 16'h0;
        mShVal  = 16'h0;
        mActDp  = 4'h0;
        mShDp   = 4'h0;
        mPend   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset", "an_n", 32'(anN), 32'hF);
        cmp("reset", "seg_n", 32'(segN), 32'hFF);
        cmp("reset", "frame_start", 32'(frameStart), 32'h0);
        cmp("reset", "pending", 32'(pending), 32'h0);
        rst = 1'b0;

        $display("[TB] idle with en low");
        repeat (8) step(1'b0, 1'b0, 16'h0, 4'h0, "idle");

        $display("[TB] vector table: first frame of 1234");
        for (int i = 0; i < 24; i++) begin
            te.name = $sformatf("vec%0d", i);
            te.an   = tbl[i].an;
            te.seg  = tbl[i].seg;
            te.fs   = tbl[i].fs;
            te.pend = tbl[i].pend;
            applyStimulus(tbl[i].en, tbl[i].ld, tbl[i].val, tbl[i].dp, 1'b1, te);
        end

        $display("[TB] two loads mid-frame, last wins");
        runUntil(6, "pre_aaaa");
        step(1'b1, 1'b1, 16'hAAAA, 4'h0, "load_aaaa");
        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, "mid");
        step(1'b1, 1'b1, 16'hBEEF, 4'h0, "load_beef");
        runUntil(0, "wait_wrap_beef");
        repeat (FRAME + 2) step(1'b1, 1'b0, 16'h0, 4'h0, "show_beef");

        $display("[TB] load on the commit cycle");
        runUntil(8, "pre_1111");
        step(1'b1, 1'b1, 16'h1111, 4'h0, "load_1111");
        runUntil(FRAME - 1, "wait_commit_edge");
        step(1'b1, 1'b1, 16'h5555, 4'h0, "load_5555_at_commit");
        repeat (FRAME) step(1'b1, 1'b0, 16'h0, 4'h0, "show_1111");
        repeat (FRAME + 2) step(1'b1, 1'b0, 16'h0, 4'h0, "show_5555");

        $display("[TB] enable dropped during digit 2");
        runUntil(2 * PER + 1, "pre_drop");
        step(1'b0, 1'b0, 16'h0, 4'h0, "en_drop");
        repeat (3) step(1'b0, 1'b0, 16'h0, 4'h0, "dark");
        repeat (FRAME + 5) step(1'b1, 1'b0, 16'h0, 4'h0, "reenable");

`ifdef SEG_SCAN_LZB_EN
        $display("[TB] leading-zero blanking");
        step(1'b1, 1'b1, 16'h0050, 4'h0, "load_0050");
        runUntil(0, "wait_0050");
        repeat (FRAME + 1) step(1'b1, 1'b0, 16'h0, 4'h0, "lzb_0050");
        step(1'b1, 1'b1, 16'h0000, 4'h0, "load_0000");
        runUntil(0, "wait_0000");
        repeat (FRAME + 1) step(1'b1, 1'b0, 16'h0, 4'h0, "lzb_0000");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
